// File: rtl/srm_dump_ctrl.sv
// -----------------------------------------------------------------------------
// srm_dump_ctrl
//
// Shares the mapper save-RAM (srm) port between live CPU accesses and a
// background dump engine. The engine walks a window of the srm address space
// and streams every byte to the host side over a valid/ready handshake. The
// CPU always wins the port. If the CPU takes the port while the engine is part
// way through a read, that read starts again from the beginning.
//
// State table:
//   IDLE | waiting for start
//   READ | engine holds ptr/oe on srm until READ_LAT clean cycles have passed
//   HOLD | captured byte presented on dump_dat, waiting for dump_rdy
//   DONE | one-cycle completion/abort pulse on done
//
// Ports:
//   clk, rst          mapper clock, synchronous active-high reset
//   cpu_req/we/oe     CPU srm access strobes for this cycle
//   cpu_addr          CPU srm address
//   start, abort      one-cycle control pulses
//   base, len         dump window, sampled when start is accepted
//   srm_ce/oe/we      memory strobes (muxed CPU / engine)
//   srm_addr          memory address (muxed CPU / engine)
//   srm_do            memory read data
//   dump_dat/vld/rdy  streamed byte handshake
//   busy              engine in READ or HOLD
//   done              completion / abort pulse
//   preempt_cnt       saturating count of engine reads restarted by the CPU
// -----------------------------------------------------------------------------
module srm_dump_ctrl #(
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_oe,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              srm_ce,
    output logic              srm_oe,
    output logic              srm_we,
    output logic [ADDR_W-1:0] srm_addr,
    input  logic [7:0]        srm_do,
    output logic [7:0]        dump_dat,
    output logic              dump_vld,
    input  logic              dump_rdy,
    output logic              busy,
    output logic              done,
    output logic [7:0]        preempt_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0]      LAT_LAST = 3'(READ_LAT - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic [ADDR_W:0]   cnt_q,      cnt_d;
    logic [2:0]        lat_q,      lat_d;
    logic [7:0]        dat_q,      dat_d;
    logic              vld_q,      vld_d;
    logic [7:0]        preempt_q,  preempt_d;

    // Port mux: the CPU always owns the port when it asks for it.
    always_comb begin
        srm_ce   = 1'b0;
        srm_oe   = 1'b0;
        srm_we   = 1'b0;
        srm_addr = ptr_q;
        if (cpu_req) begin
            srm_ce   = 1'b1;
            srm_oe   = cpu_oe;
            srm_we   = cpu_we;
            srm_addr = cpu_addr;
        end else if (state_q == ST_READ) begin
            srm_ce   = 1'b1;
            srm_oe   = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        dat_d     = dat_q;
        vld_d     = vld_q;
        preempt_d = preempt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d     = base;
                    cnt_d     = len;
                    lat_d     = 3'd0;
                    preempt_d = 8'd0;
                    state_d   = (len == '0) ? ST_DONE : ST_READ;
                end
            end

            ST_READ: begin
                if (abort) begin
                    vld_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cpu_req) begin
                    // A restart only counts if the engine had already made progress.
                    lat_d = 3'd0;
                    if (lat_q != 3'd0 && preempt_q != 8'hFF) begin
                        preempt_d = preempt_q + 8'd1;
                    end
                end else if (lat_q == LAT_LAST) begin
                    dat_d   = srm_do;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end

            ST_HOLD: begin
                // abort beats a simultaneous handshake: the byte is dropped untransferred.
                if (abort) begin
                    vld_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (dump_rdy) begin
                    vld_d   = 1'b0;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - CNT_ONE;
                    lat_d   = 3'd0;
                    state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_READ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= 3'd0;
            dat_q     <= 8'd0;
            vld_q     <= 1'b0;
            preempt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            dat_q     <= dat_d;
            vld_q     <= vld_d;
            preempt_q <= preempt_d;
        end
    end

    assign dump_dat    = dat_q;
    assign dump_vld    = vld_q;
    assign busy        = (state_q == ST_READ) || (state_q == ST_HOLD);
    assign done        = (state_q == ST_DONE);
    assign preempt_cnt = preempt_q;

endmodule
